// File: rtl/frogger_game_ctrl_if.sv
// Board-side signal bundle for the frogger sequencer: buttons and lane occupancy in,
// lane time-base pulses, frog position and game status out.
interface frogger_game_ctrl_if;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic [63:0] lanes;
  logic        lane_tick;
  logic        lane_clear;
  logic [2:0]  frog_row;
  logic [2:0]  frog_col;
  logic [1:0]  lives;
  logic [1:0]  level;
  logic [2:0]  state;
  logic        win;
  logic        game_over;

  modport master (
    output up, down, left, right, lanes,
    input  lane_tick, lane_clear, frog_row, frog_col, lives, level, state, win, game_over
  );

  modport slave (
    input  up, down, left, right, lanes,
    output lane_tick, lane_clear, frog_row, frog_col, lives, level, state, win, game_over
  );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: button edges, frog tracking, collision, lane ticks, lives/level.
// Optional attempt timeout enabled by defining FROGGER_TIMEOUT_EN.
module frogger_game_ctrl #(
  parameter int unsigned TICK_DIV    = 8,
  parameter int unsigned START_LIVES = 3,
  parameter int unsigned HOLD_CYC    = 4
`ifdef FROGGER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_TICKS = 32
`endif
) (
  input logic              clk,
  input logic              reset,
  frogger_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t      r_state;
  logic [3:0]  r_btn_cur;
  logic [3:0]  r_btn_prev;
  logic [2:0]  r_frog_row;
  logic [2:0]  r_frog_col;
  logic [1:0]  r_lives;
  logic [1:0]  r_level;
  logic [31:0] r_tick_cnt;
  logic [31:0] r_hold;
  logic        r_lane_tick;
  logic        r_lane_clear;
  logic        r_win;
  logic        r_game_over;

  logic [3:0]  w_press;
  logic        w_any_press;
  logic [31:0] w_shifted;
  logic [31:0] w_period;
  logic        w_tick_due;
  logic        w_lane_hit;
  logic        w_hold_done;
  logic        w_timeout;

  // Buttons are active-low: {up,down,left,right}, a press is a registered 1->0 edge
  assign w_press     = r_btn_prev & ~r_btn_cur;
  assign w_any_press = |w_press;
  assign w_shifted   = TICK_DIV >> r_level;
  assign w_period    = (w_shifted == '0) ? 32'd1 : w_shifted;
  assign w_tick_due  = (r_tick_cnt == w_period - 32'd1);
  assign w_lane_hit  = bus.lanes[{r_frog_row, r_frog_col}];
  assign w_hold_done = (r_hold == HOLD_CYC - 1);

`ifdef FROGGER_TIMEOUT_EN
  logic [31:0] r_attempt;

  // Cleared whenever outside PLAY, which covers every entry into PLAY
  always_ff @(posedge clk) begin
    if (reset || r_state != S_PLAY) begin
      r_attempt <= '0;
    end else if (w_tick_due && r_frog_row != 3'd0 && !w_lane_hit) begin
      r_attempt <= r_attempt + 32'd1;
    end
  end

  assign w_timeout = w_tick_due && (r_attempt == TIMEOUT_TICKS - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_btn_cur    <= '1;
      r_btn_prev   <= '1;
      r_frog_row   <= 3'd7;
      r_frog_col   <= 3'd3;
      r_lives      <= 2'(START_LIVES);
      r_level      <= '0;
      r_tick_cnt   <= '0;
      r_hold       <= '0;
      r_lane_tick  <= 1'b0;
      r_lane_clear <= 1'b1;
      r_win        <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_btn_cur    <= {bus.up, bus.down, bus.left, bus.right};
      r_btn_prev   <= r_btn_cur;
      r_lane_tick  <= 1'b0;
      r_lane_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tick_cnt <= '0;
          if (w_any_press) begin
            r_state      <= S_PLAY;
            r_lane_clear <= 1'b1;
          end
        end
        S_PLAY: begin
          if (r_frog_row == 3'd0) begin
            r_state    <= S_WIN;
            r_win      <= 1'b1;
            r_tick_cnt <= '0;
            r_hold     <= '0;
            if (r_level != 2'd3) r_level <= r_level + 2'd1;
          end else if (w_lane_hit || w_timeout) begin
            r_state     <= S_HIT;
            r_tick_cnt  <= '0;
            r_hold      <= '0;
            r_lane_tick <= w_timeout && !w_lane_hit;
            if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
          end else begin
            if (w_tick_due) begin
              r_tick_cnt  <= '0;
              r_lane_tick <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + 32'd1;
            end
            // Only the highest-priority press is considered; if it is blocked, nothing moves
            if (w_press[3]) begin
              r_frog_row <= r_frog_row - 3'd1;
            end else if (w_press[2]) begin
              if (r_frog_row != 3'd7) r_frog_row <= r_frog_row + 3'd1;
            end else if (w_press[1]) begin
              if (r_frog_col != 3'd0) r_frog_col <= r_frog_col - 3'd1;
            end else if (w_press[0]) begin
              if (r_frog_col != 3'd7) r_frog_col <= r_frog_col + 3'd1;
            end
          end
        end
        S_HIT: begin
          if (w_hold_done) begin
            if (r_lives == 2'd0) begin
              r_state     <= S_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state      <= S_PLAY;
              r_frog_row   <= 3'd7;
              r_frog_col   <= 3'd3;
              r_lane_clear <= 1'b1;
            end
          end else begin
            r_hold <= r_hold + 32'd1;
          end
        end
        S_WIN: begin
          if (w_hold_done) begin
            r_state      <= S_PLAY;
            r_win        <= 1'b0;
            r_frog_row   <= 3'd7;
            r_frog_col   <= 3'd3;
            r_lane_clear <= 1'b1;
          end else begin
            r_hold <= r_hold + 32'd1;
          end
        end
        S_OVER: begin
          if (w_any_press) begin
            r_state     <= S_IDLE;
            r_game_over <= 1'b0;
            r_lives     <= 2'(START_LIVES);
            r_level     <= '0;
            r_frog_row  <= 3'd7;
            r_frog_col  <= 3'd3;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.lane_tick  = r_lane_tick;
  assign bus.lane_clear = r_lane_clear;
  assign bus.frog_row   = r_frog_row;
  assign bus.frog_col   = r_frog_col;
  assign bus.lives      = r_lives;
  assign bus.level      = r_level;
  assign bus.state      = r_state;
  assign bus.win        = r_win;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Scoreboard bench for frogger_game_ctrl: directed game scenarios plus random play,
// checked cycle by cycle against a behavioural game model.
module tb_frogger_game_ctrl;
  localparam int unsigned TICK_DIV    = 8;
  localparam int unsigned START_LIVES = 3;
  localparam int unsigned HOLD_CYC    = 4;
  localparam logic [3:0]  NONE        = 4'b1111;

  logic clk;
  logic reset;

  frogger_game_ctrl_if bus();

  frogger_game_ctrl #(
    .TICK_DIV(TICK_DIV),
    .START_LIVES(START_LIVES),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int state;
    int row;
    int col;
    int lives;
    int level;
    int tick;
    int clear;
    int win;
    int over;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Game model: states 0 idle, 1 play, 2 hit, 3 win, 4 over
  int         m_state, m_row, m_col, m_lives, m_level, m_hold, m_play_cycles;
  int         m_tick, m_clear;
  logic [3:0] m_last1, m_last2;

  function automatic exp_t model_step(input logic [3:0] b, input logic [63:0] ln, input logic rst);
    exp_t       e;
    logic [3:0] press;
    int         period;
    if (rst) begin
      m_state = 0; m_row = 7; m_col = 3; m_lives = START_LIVES; m_level = 0;
      m_hold = 0; m_play_cycles = 0; m_tick = 0; m_clear = 1;
      m_last1 = '1; m_last2 = '1;
    end else begin
      // Decision at this edge sees the inputs sampled at the two previous edges
      press   = m_last2 & ~m_last1;
      m_last2 = m_last1;
      m_last1 = b;
      m_tick  = 0;
      m_clear = 0;
      case (m_state)
        0: if (press != 0) begin
          m_state = 1; m_clear = 1; m_play_cycles = 0;
        end
        1: begin
          if (m_row == 0) begin
            m_state = 3; m_hold = 0;
            m_level = (m_level < 3) ? m_level + 1 : 3;
          end else if (ln[8*m_row + m_col]) begin
            m_state = 2; m_hold = 0;
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          end else begin
            period = int'(TICK_DIV >> m_level);
            if (period < 1) period = 1;
            m_play_cycles++;
            if (m_play_cycles % period == 0) m_tick = 1;
            if (press[3]) m_row = m_row - 1;
            else if (press[2]) begin if (m_row < 7) m_row = m_row + 1; end
            else if (press[1]) begin if (m_col > 0) m_col = m_col - 1; end
            else if (press[0]) begin if (m_col < 7) m_col = m_col + 1; end
          end
        end
        2: begin
          m_hold++;
          if (m_hold == HOLD_CYC) begin
            if (m_lives == 0) m_state = 4;
            else begin
              m_state = 1; m_row = 7; m_col = 3; m_clear = 1; m_play_cycles = 0;
            end
          end
        end
        3: begin
          m_hold++;
          if (m_hold == HOLD_CYC) begin
            m_state = 1; m_row = 7; m_col = 3; m_clear = 1; m_play_cycles = 0;
          end
        end
        default: if (press != 0) begin
          m_state = 0; m_lives = START_LIVES; m_level = 0; m_row = 7; m_col = 3;
        end
      endcase
    end
    e.state = m_state; e.row = m_row; e.col = m_col; e.lives = m_lives; e.level = m_level;
    e.tick = m_tick; e.clear = m_clear;
    e.win = (m_state == 3) ? 1 : 0;
    e.over = (m_state == 4) ? 1 : 0;
    return e;
  endfunction

  task automatic step(input logic [3:0] b, input logic [63:0] ln, input logic rst);
    exp_t e;
    {bus.up, bus.down, bus.left, bus.right} = b;
    bus.lanes = ln;
    reset     = rst;
    e = model_step(b, ln, rst);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_n(input int n, input logic [63:0] ln);
    for (int i = 0; i < n; i++) step(NONE, ln, 1'b0);
  endtask

  task automatic press(input logic [3:0] b, input logic [63:0] ln);
    step(b, ln, 1'b0);
    step(NONE, ln, 1'b0);
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input int expv);
    checks++;
    if (act !== 32'(expv)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("state",      32'(bus.state),      e.state);
      chk("frog_row",   32'(bus.frog_row),   e.row);
      chk("frog_col",   32'(bus.frog_col),   e.col);
      chk("lives",      32'(bus.lives),      e.lives);
      chk("level",      32'(bus.level),      e.level);
      chk("lane_tick",  32'(bus.lane_tick),  e.tick);
      chk("lane_clear", 32'(bus.lane_clear), e.clear);
      chk("win",        32'(bus.win),        e.win);
      chk("game_over",  32'(bus.game_over),  e.over);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  btn;
    logic [63:0] ln;
    logic [63:0] car63;
    car63 = 64'd1 << 51;

    // Reset, then idle with no presses
    step(NONE, '0, 1'b1);
    step(NONE, '0, 1'b1);
    idle_n(5, '0);

    // Start game, observe level-0 ticks, then a long hold that must move only once
    press(4'b0111, '0);
    idle_n(20, '0);
    for (int i = 0; i < 20; i++) step(4'b0111, '0, 1'b0);
    idle_n(4, '0);
    press(4'b0011, '0);
    idle_n(3, '0);
    for (int i = 0; i < 6; i++) press(4'b1110, '0);
    press(4'b1011, '0);
    idle_n(3, '0);

    // Reset mid-game, then three collisions at (6,3) to reach game over
    step(NONE, '0, 1'b1);
    press(4'b0111, car63);
    idle_n(3, car63);
    for (int k = 0; k < 3; k++) begin
      press(4'b0111, car63);
      idle_n(8, car63);
    end
    idle_n(3, '0);
    press(4'b1101, '0);
    idle_n(3, '0);

    // Four wins: level saturates at 3 and tick period shrinks to 1
    press(4'b0111, '0);
    for (int w = 0; w < 4; w++) begin
      idle_n(2, '0);
      for (int u = 0; u < 7; u++) press(4'b0111, '0);
      idle_n(12, '0);
    end
    idle_n(10, '0);

    // Random play with sparse traffic and occasional reset
    btn = NONE;
    ln  = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 16 == 0) begin
        if ($urandom_range(3) == 0) ln = '0;
        else ln = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      end
      if ($urandom_range(3) == 0) btn = 4'($urandom) | 4'($urandom);
      step(btn, ln, ($urandom_range(399) == 0) ? 1'b1 : 1'b0);
    end
    idle_n(4, '0);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
